// File: rtl/xcel_conv_compute.sv
// Naive convolution compute unit for one (input channel, output channel) pair.
// Issues byte reads for IFM/WT, multiply-accumulates a WT_DIM x WT_DIM window, then writes the OFM word.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for start; latches dims and accumulate
// S_CLR     | clears accumulator for a new output pixel
// S_REQ_IFM | requests IFM byte at current tap
// S_REQ_WT  | requests WT byte at current tap
// S_MAC     | acc += ifm*wt, advances kx/ky
// S_REQ_OFM | reads old OFM partial sum (accumulate mode)
// S_WR_OFM  | writes acc to OFM, advances x/y
// S_DONE    | one-cycle done pulse
module xcel_conv_compute #(
  parameter int DWIDTH    = 8,
  parameter int WT_DIM    = 5,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          ifm_dim,
  input  logic                 accumulate,
  output logic                 idle,
  output logic                 done,
  output logic [31:0]          ifm_addr,
  input  logic [DWIDTH-1:0]    ifm_dout,
  input  logic                 ifm_dout_valid,
  output logic                 ifm_dout_ready,
  output logic [31:0]          wt_addr,
  input  logic [DWIDTH-1:0]    wt_dout,
  input  logic                 wt_dout_valid,
  output logic                 wt_dout_ready,
  output logic [31:0]          ofm_addr0,
  input  logic [ACC_WIDTH-1:0] ofm_dout0,
  input  logic                 ofm_dout0_valid,
  output logic                 ofm_dout0_ready,
  output logic [31:0]          ofm_addr1,
  output logic [ACC_WIDTH-1:0] ofm_din1,
  output logic                 ofm_din1_valid,
  input  logic                 ofm_din1_ready,
  output logic                 ofm_we1
);

  localparam int KW = (WT_DIM > 1) ? $clog2(WT_DIM) : 1;
  localparam int PW = 2 * DWIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(WT_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_REQ_IFM, S_REQ_WT, S_MAC, S_REQ_OFM, S_WR_OFM, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           ifm_dim_q, ifm_dim_d;
  logic [15:0]           ofm_dim_q, ofm_dim_d;
  logic                  accum_q, accum_d;
  logic [15:0]           y_q, y_d, x_q, x_d;
  logic [KW-1:0]         ky_q, ky_d, kx_q, kx_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DWIDTH-1:0]     ifm_q, ifm_d, wt_q, wt_d;

  logic signed [PW-1:0]  prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [31:0]           row_w, col_w;

  assign prod     = $signed(ifm_q) * $signed(wt_q);
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  assign row_w     = 32'(y_q) + 32'(ky_q);
  assign col_w     = 32'(x_q) + 32'(kx_q);
  assign ifm_addr  = row_w * 32'(ifm_dim_q) + col_w;
  assign wt_addr   = 32'(ky_q) * 32'(WT_DIM) + 32'(kx_q);
  assign ofm_addr0 = 32'(y_q) * 32'(ofm_dim_q) + 32'(x_q);
  assign ofm_addr1 = ofm_addr0;
  assign ofm_din1  = acc_q;
  assign ofm_we1   = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ifm_dim_q <= '0;
      ofm_dim_q <= '0;
      accum_q   <= 1'b0;
      y_q       <= '0;
      x_q       <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      acc_q     <= '0;
      ifm_q     <= '0;
      wt_q      <= '0;
    end else begin
      state_q   <= state_d;
      ifm_dim_q <= ifm_dim_d;
      ofm_dim_q <= ofm_dim_d;
      accum_q   <= accum_d;
      y_q       <= y_d;
      x_q       <= x_d;
      ky_q      <= ky_d;
      kx_q      <= kx_d;
      acc_q     <= acc_d;
      ifm_q     <= ifm_d;
      wt_q      <= wt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ifm_dim_d       = ifm_dim_q;
    ofm_dim_d       = ofm_dim_q;
    accum_d         = accum_q;
    y_d             = y_q;
    x_d             = x_q;
    ky_d            = ky_q;
    kx_d            = kx_q;
    acc_d           = acc_q;
    ifm_d           = ifm_q;
    wt_d            = wt_q;
    idle            = 1'b0;
    done            = 1'b0;
    ifm_dout_ready  = 1'b0;
    wt_dout_ready   = 1'b0;
    ofm_dout0_ready = 1'b0;
    ofm_din1_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        idle = 1'b1;
        if (start) begin
          ifm_dim_d = ifm_dim;
          ofm_dim_d = ifm_dim - 16'(WT_DIM - 1);
          accum_d   = accumulate;
          y_d       = '0;
          x_d       = '0;
          ky_d      = '0;
          kx_d      = '0;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        acc_d   = '0;
        state_d = S_REQ_IFM;
      end
      S_REQ_IFM: begin
        ifm_dout_ready = 1'b1;
        if (ifm_dout_valid) begin
          ifm_d   = ifm_dout;
          state_d = S_REQ_WT;
        end
      end
      S_REQ_WT: begin
        wt_dout_ready = 1'b1;
        if (wt_dout_valid) begin
          wt_d    = wt_dout;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_REQ_IFM;
        if (kx_q == K_LAST) begin
          kx_d = '0;
          if (ky_q == K_LAST) begin
            ky_d    = '0;
            state_d = accum_q ? S_REQ_OFM : S_WR_OFM;
          end else begin
            ky_d = ky_q + 1'b1;
          end
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      S_REQ_OFM: begin
        ofm_dout0_ready = 1'b1;
        if (ofm_dout0_valid) begin
          acc_d   = acc_q + ofm_dout0;
          state_d = S_WR_OFM;
        end
      end
      S_WR_OFM: begin
        ofm_din1_valid = 1'b1;
        if (ofm_din1_ready) begin
          state_d = S_CLR;
          if (x_q == ofm_dim_q - 16'd1) begin
            x_d = '0;
            if (y_q == ofm_dim_q - 16'd1) begin
              y_d     = '0;
              state_d = S_DONE;
            end else begin
              y_d = y_q + 16'd1;
            end
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xcel_conv_compute.sv
// Directed bench for xcel_conv_compute with a latency-configurable memory responder.
// Tracks request exclusivity/stability and logs every OFM read and write.
module tb_xcel_conv_compute;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ifm_dim;
  logic        accumulate;
  logic        idle, done;
  logic [31:0] ifm_addr, wt_addr, ofm_addr0, ofm_addr1;
  logic [7:0]  ifm_dout, wt_dout;
  logic        ifm_dout_valid, ifm_dout_ready;
  logic        wt_dout_valid, wt_dout_ready;
  logic [31:0] ofm_dout0, ofm_din1;
  logic        ofm_dout0_valid, ofm_dout0_ready;
  logic        ofm_din1_valid, ofm_din1_ready, ofm_we1;

  always #5 clk = ~clk;

  xcel_conv_compute dut (
    .clk(clk), .rst(rst), .start(start), .ifm_dim(ifm_dim), .accumulate(accumulate),
    .idle(idle), .done(done),
    .ifm_addr(ifm_addr), .ifm_dout(ifm_dout), .ifm_dout_valid(ifm_dout_valid), .ifm_dout_ready(ifm_dout_ready),
    .wt_addr(wt_addr), .wt_dout(wt_dout), .wt_dout_valid(wt_dout_valid), .wt_dout_ready(wt_dout_ready),
    .ofm_addr0(ofm_addr0), .ofm_dout0(ofm_dout0), .ofm_dout0_valid(ofm_dout0_valid), .ofm_dout0_ready(ofm_dout0_ready),
    .ofm_addr1(ofm_addr1), .ofm_din1(ofm_din1), .ofm_din1_valid(ofm_din1_valid), .ofm_din1_ready(ofm_din1_ready),
    .ofm_we1(ofm_we1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  logic [7:0]  ifm_mem [64];
  logic [7:0]  wt_mem  [25];
  logic [31:0] ofm_old_base = 32'd0;
  int unsigned lat_max  = 0;
  bit          spurious = 1'b0;

  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] rd_addr_q [$];
  int n_ifm, n_wt, n_done, busy_cyc;
  int viol_mutex = 0;
  int viol_stable = 0;

  function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // memory responder plus exclusivity/stability monitor, all at negedge
  initial begin
    int unsigned ci, cw, co, cr;
    logic pi, pw, po, pv;
    logic [31:0] ai, aw, ao, av, dv;
    ci = 0; cw = 0; co = 0; cr = 0;
    pi = 0; pw = 0; po = 0; pv = 0;
    ai = 0; aw = 0; ao = 0; av = 0; dv = 0;
    ifm_dout = 0; wt_dout = 0; ofm_dout0 = 0;
    ifm_dout_valid = 0; wt_dout_valid = 0; ofm_dout0_valid = 0; ofm_din1_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pi = 0; pw = 0; po = 0; pv = 0;
      end else begin
        if (int'(ifm_dout_ready) + int'(wt_dout_ready) + int'(ofm_dout0_ready) + int'(ofm_din1_valid) > 1)
          viol_mutex++;
        if (pi && !ifm_dout_valid && (!ifm_dout_ready || ifm_addr != ai)) viol_stable++;
        if (pw && !wt_dout_valid && (!wt_dout_ready || wt_addr != aw)) viol_stable++;
        if (po && !ofm_dout0_valid && (!ofm_dout0_ready || ofm_addr0 != ao)) viol_stable++;
        if (pv && !ofm_din1_ready && (!ofm_din1_valid || ofm_addr1 != av || ofm_din1 != dv)) viol_stable++;
        if (!idle) busy_cyc++;
        if (done) n_done++;
        pi = ifm_dout_ready;  ai = ifm_addr;
        pw = wt_dout_ready;   aw = wt_addr;
        po = ofm_dout0_ready; ao = ofm_addr0;
        pv = ofm_din1_valid;  av = ofm_addr1; dv = ofm_din1;
      end

      ifm_dout_valid = 0; wt_dout_valid = 0; ofm_dout0_valid = 0; ofm_din1_ready = 0;
      if (ifm_dout_ready && !rst) begin
        if (ci > 0) ci--;
        else begin
          ifm_dout_valid = 1;
          ifm_dout = (ifm_addr < 64) ? ifm_mem[ifm_addr[5:0]] : 8'h00;
          n_ifm++;
          ci = $urandom_range(lat_max, 0);
        end
      end else if (spurious && $urandom_range(3, 0) == 0) begin
        ifm_dout_valid = 1; ifm_dout = 8'h5A;
      end
      if (wt_dout_ready && !rst) begin
        if (cw > 0) cw--;
        else begin
          wt_dout_valid = 1;
          wt_dout = (wt_addr < 25) ? wt_mem[wt_addr[4:0]] : 8'h00;
          n_wt++;
          cw = $urandom_range(lat_max, 0);
        end
      end else if (spurious && $urandom_range(3, 0) == 0) begin
        wt_dout_valid = 1; wt_dout = 8'hA5;
      end
      if (ofm_dout0_ready && !rst) begin
        if (cr > 0) cr--;
        else begin
          ofm_dout0_valid = 1;
          ofm_dout0 = ofm_old_base + ofm_addr0;
          rd_addr_q.push_back(ofm_addr0);
          cr = $urandom_range(lat_max, 0);
        end
      end else if (spurious && $urandom_range(3, 0) == 0) begin
        ofm_dout0_valid = 1; ofm_dout0 = 32'h7777_7777;
      end
      if (ofm_din1_valid && !rst) begin
        if (co > 0) co--;
        else begin
          ofm_din1_ready = 1;
          wr_addr_q.push_back(ofm_addr1);
          wr_data_q.push_back(ofm_din1);
          co = $urandom_range(lat_max, 0);
        end
      end else if (spurious && $urandom_range(3, 0) == 0) begin
        ofm_din1_ready = 1;
      end
    end
  end

  function automatic logic [31:0] conv_ref(input int dim, input int y, input int x, input bit acc);
    logic signed [31:0] s;
    int od;
    s  = 0;
    od = dim - 4;
    for (int ky = 0; ky < 5; ky++)
      for (int kx = 0; kx < 5; kx++)
        s += $signed(ifm_mem[(y+ky)*dim + x + kx]) * $signed(wt_mem[ky*5 + kx]);
    if (acc) s += ofm_old_base + 32'(y*od + x);
    return s;
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    n_ifm = 0; n_wt = 0; n_done = 0; busy_cyc = 0;
  endtask

  // one pass; optionally pulses a stray start with another dim mid-pass
  task automatic run_pass(input int dim, input bit acc, input int budget, input bit stray_start);
    clear_logs();
    @(negedge clk); #1;
    ifm_dim = 16'(dim); accumulate = acc; start = 1;
    @(negedge clk); #1;
    start = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (stray_start && c == 10) begin start = 1; ifm_dim = 16'd5; accumulate = ~acc; end
      if (stray_start && c == 11) begin start = 0; ifm_dim = 16'(dim); accumulate = acc; end
      if (n_done > 0) break;
    end
    start = 0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit seen;
    rst = 1; start = 0; ifm_dim = 16'd5; accumulate = 0;
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'd0;
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'd0;
    #22;
    chk("rst_idle", 32'(idle), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_reqs", 32'({ifm_dout_ready, wt_dout_ready, ofm_dout0_ready, ofm_din1_valid}), 0);
    chk("rst_ifm_addr", ifm_addr, 0);
    chk("rst_ofm_addr1", ofm_addr1, 0);
    chk("rst_we1", 32'(ofm_we1), 1);
    @(negedge clk); rst = 0;

    // all ones times all twos, single pixel
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'd1;
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'd2;
    run_pass(5, 0, 2000, 0);
    chk("t1_done", 32'(n_done), 1);
    chk("t1_nwr", 32'(wr_addr_q.size()), 1);
    chk("t1_addr", q_at(wr_addr_q, 0), 0);
    chk("t1_data", q_at(wr_data_q, 0), 50);
    chk("t1_nifm", 32'(n_ifm), 25);
    chk("t1_nwt", 32'(n_wt), 25);
    chk("t1_nrd", 32'(rd_addr_q.size()), 0);
    chk("t1_cycles", 32'(busy_cyc), 78);
    chk("t1_idle", 32'(idle), 1);

    // delta kernel copies IFM top-left window origin; stray start must be ignored
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'(i % 128);
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'd0;
    wt_mem[0] = 8'd1;
    run_pass(6, 0, 4000, 1);
    chk("t2_done", 32'(n_done), 1);
    chk("t2_nwr", 32'(wr_addr_q.size()), 4);
    chk("t2_nifm", 32'(n_ifm), 100);
    chk("t2_a0", q_at(wr_addr_q, 0), 0);
    chk("t2_d0", q_at(wr_data_q, 0), 0);
    chk("t2_a1", q_at(wr_addr_q, 1), 1);
    chk("t2_d1", q_at(wr_data_q, 1), 1);
    chk("t2_a2", q_at(wr_addr_q, 2), 2);
    chk("t2_d2", q_at(wr_data_q, 2), 6);
    chk("t2_a3", q_at(wr_addr_q, 3), 3);
    chk("t2_d3", q_at(wr_data_q, 3), 7);

    // most-negative operands
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'h80;
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'h80;
    run_pass(5, 0, 2000, 0);
    chk("t3_data", q_at(wr_data_q, 0), 409600);

    // negative product: -1 * 3 over 25 taps
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'hFF;
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'd3;
    run_pass(5, 0, 2000, 0);
    chk("t3b_data", q_at(wr_data_q, 0), 32'hFFFF_FFB5);

    // read-modify-write
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'd1;
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'd1;
    ofm_old_base = 32'd100;
    run_pass(5, 1, 2000, 0);
    chk("t4_nrd", 32'(rd_addr_q.size()), 1);
    chk("t4_rdaddr", q_at(rd_addr_q, 0), 0);
    chk("t4_data", q_at(wr_data_q, 0), 125);

    // random latency, spurious valids, accumulate, 3x3 output
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'((i * 37 + 11) & 255);
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'((i * 13 + 200) & 255);
    ofm_old_base = 32'd1000;
    lat_max = 7; spurious = 1;
    run_pass(7, 1, 20000, 0);
    chk("t5_done", 32'(n_done), 1);
    chk("t5_nwr", 32'(wr_addr_q.size()), 9);
    chk("t5_nrd", 32'(rd_addr_q.size()), 9);
    for (int p = 0; p < 9; p++) begin
      chk($sformatf("t5_a%0d", p), q_at(wr_addr_q, p), 32'(p));
      chk($sformatf("t5_d%0d", p), q_at(wr_data_q, p), conv_ref(7, p / 3, p % 3, 1));
    end
    spurious = 0;

    // async reset while waiting on WT
    lat_max = 3;
    for (int i = 0; i < 64; i++) ifm_mem[i] = 8'd1;
    for (int i = 0; i < 25; i++) wt_mem[i] = 8'd2;
    clear_logs();
    @(negedge clk); #1;
    ifm_dim = 16'd5; accumulate = 0; start = 1;
    @(negedge clk); #1;
    start = 0;
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk); #1;
      if (wt_dout_ready && n_wt >= 3) seen = 1;
    end
    chk("t6_reach_wt", 32'(seen), 1);
    #2 rst = 1;
    #1;
    chk("t6_reqs", 32'({ifm_dout_ready, wt_dout_ready, ofm_dout0_ready, ofm_din1_valid}), 0);
    chk("t6_idle", 32'(idle), 1);
    chk("t6_nwr", 32'(wr_addr_q.size()), 0);
    @(negedge clk); #1;
    rst = 0;
    run_pass(5, 0, 4000, 0);
    chk("t6_done", 32'(n_done), 1);
    chk("t6_nwr2", 32'(wr_addr_q.size()), 1);
    chk("t6_data", q_at(wr_data_q, 0), 50);
    chk("t6_nifm", 32'(n_ifm), 25);

    chk("mutex_viol", 32'(viol_mutex), 0);
    chk("stable_viol", 32'(viol_stable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xcel_conv_compute.md
Name: xcel_conv_compute

Overview:
- Naive convolution compute unit for one (input channel, output channel) pair.
- Sits directly upstream of the naive memory interface and drives its IFM/WT/OFM request ports.
- For each output pixel it issues byte reads for IFM and WT, multiply-accumulates over a WT_DIM x WT_DIM window, optionally reads the old OFM partial sum, then writes the 32-bit result back.
- Started and sequenced once per channel pair by the accelerator top.

Parameters:
- DWIDTH, 8, IFM/WT element width (signed two's complement).
- WT_DIM, 5, kernel height and width.
- ACC_WIDTH, 32, accumulator and OFM word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; starts a channel pass; sampled only in IDLE
- ifm_dim  in  16  IFM height = width (elements); must be >= WT_DIM
- accumulate  in  1  1: OFM += sum (read-modify-write); 0: OFM = sum; latched at start
- idle  out  1  high in IDLE
- done  out  1  one-cycle pulse when the pass completes
- ifm_addr  out  32  IFM element (byte) index
- ifm_dout  in  DWIDTH  IFM byte
- ifm_dout_valid  in  1  IFM data valid
- ifm_dout_ready  out  1  IFM read request
- wt_addr  out  32  WT element index
- wt_dout  in  DWIDTH  WT byte
- wt_dout_valid  in  1  WT data valid
- wt_dout_ready  out  1  WT read request
- ofm_addr0  out  32  OFM word index (read)
- ofm_dout0  in  32  OFM old value
- ofm_dout0_valid  in  1  OFM read data valid
- ofm_dout0_ready  out  1  OFM read request
- ofm_addr1  out  32  OFM word index (write)
- ofm_din1  out  32  OFM write data
- ofm_din1_valid  out  1  OFM write request
- ofm_din1_ready  in  1  OFM write accepted
- ofm_we1  out  1  tied 1

Behaviour:
- Reset: state IDLE; all request/valid outputs 0, done 0, idle 1, counters and accumulator 0, address outputs 0.
- ofm_dim = ifm_dim - WT_DIM + 1, computed at start and latched with ifm_dim and accumulate.
- Counters: y, x over [0, ofm_dim); ky, kx over [0, WT_DIM). kx is innermost, then ky, then x, then y.
- Address outputs are driven combinationally from registered counters:
  - ifm_addr = (y+ky)*ifm_dim + (x+kx)
  - wt_addr = ky*WT_DIM + kx
  - ofm_addr0 = ofm_addr1 = y*ofm_dim + x
- States:
  - IDLE: start -> CLR.
  - CLR: acc <= 0 -> REQ_IFM.
  - REQ_IFM: ifm_dout_ready=1. On ifm_dout_valid, latch byte -> REQ_WT.
  - REQ_WT: wt_dout_ready=1. On wt_dout_valid, latch byte -> MAC.
  - MAC: acc <= acc + sext(ifm)*sext(wt); product is 2*DWIDTH signed, sign-extended to ACC_WIDTH; wrap modulo 2^ACC_WIDTH, no saturation. Advance kx/ky. If the window is complete: go to REQ_OFM if accumulate, else WR_OFM. Otherwise -> REQ_IFM.
  - REQ_OFM: ofm_dout0_ready=1. On ofm_dout0_valid, acc <= acc + ofm_dout0 -> WR_OFM.
  - WR_OFM: ofm_din1_valid=1, ofm_din1=acc. On ofm_din1_ready: advance x/y, then go to DONE if the last pixel was written, else CLR.
  - DONE: done=1 for one cycle -> IDLE.
- Handshake rules:
  - At most one of the three *_ready request lines and ofm_din1_valid is high at any time.
  - A request and its address stay stable from assertion until the matching valid (or ofm_din1_ready) is seen.
  - The request drops in the cycle after that acceptance, because the request lines are decoded from the registered state.
  - A valid on a port that is not currently requested is ignored.
  - The memory side may take any number of cycles; no timeout.
- Latency: with a memory side taking R cycles per read and W cycles per write, each tap costs 2R+1 cycles.
- Boundaries and special cases:
  - ifm_dim == WT_DIM gives exactly one output pixel.
  - start while not IDLE is ignored.
  - Asynchronous rst mid-pass returns the block to the reset state immediately; the partial pixel is abandoned.

Test Plan:
- ifm_dim=5, accumulate=0, IFM all 1, WT all 2, 1-cycle memory model -> one write: ofm_addr1=0, ofm_din1=50; done pulses once; exactly 25 IFM and 25 WT requests.
- ifm_dim=6, accumulate=0, IFM[i]=i mod 128, WT=delta at index 0 -> four writes at addresses 0,1,2,3 with data 0,1,6,7.
- Signed check: IFM=-128 (0x80), WT=-128, ifm_dim=5 -> ofm_din1 = 25*16384 = 409600.
- accumulate=1, ifm_dim=5, IFM=1, WT=1, ofm_dout0=100 -> one OFM read at address 0, write of 125; with accumulate=0, no ofm_dout0_ready is ever asserted.
- Random 0-7 cycle memory latency, spurious valids on unrequested ports -> results match the golden model; requests are mutually exclusive and stable until accepted.
- rst asserted during REQ_WT -> all requests drop asynchronously and idle=1; a new start completes a full, correct pass.
